bru_bpred: RTL and testbench
============================

// Module: bru_bpred
// PURPOSE
//  Parametrised branch resolution unit with a built-in direct-mapped BTB and 2-bit
//  direction predictor. IF looks up pred_pc combinationally. EX resolves jal/jalr/
//  b* and flags mispredicts. The table trains on the clock edge after resolution.
//  Saturating perf counters track branch and mispredict counts.
// PARAMETERS
//  XLEN      32  datapath/address width
//  ENTRIES   16  BTB entries; power of 2, >=2; IDX=log2(ENTRIES)
//  CNT_W     32  width of each perf counter
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        reset: synchronous, active-high
//  pred_pc      in   XLEN     IF fetch pc (lookup)
//  pred_taken   out  1        predicted taken
//  pred_target  out  XLEN     predicted target (valid when pred_taken)
//  ex_valid     in   1        EX holds a real instruction this cycle
//  ex_flush     in   1        EX instr squashed: no redirect, no train, no count
//  jump_type    in   8        one-hot {bgeu,bltu,bge,blt,bne,beq,jalr,jal} (bit0=jal)
//  src1, src2   in   XLEN     rs1/rs2 operands
//  pc, imm      in   XLEN     EX pc, sign-extended immediate
//  ex_pred_taken  in 1        prediction that was carried down with this instr
//  ex_pred_target in XLEN     predicted target carried down with this instr
//  taken        out  1        resolved direction
//  target       out  XLEN     resolved target
//  mispredict   out  1        redirect request
//  redirect_pc  out  XLEN     taken ? target : pc+4
//  br_count     out  CNT_W    resolved control-transfer instr count
//  mis_count    out  CNT_W    mispredict count
// BEHAVIOUR
//  - act = ex_valid & ~ex_flush & (jump_type one-hot). Zero or multi-hot jump_type is
//    not a branch: taken=0, mispredict=0, no train, no count.
//  - Resolution is combinational, 0 latency. Compares use the signed and unsigned forms
//    of XLEN. jal target=pc+imm. jalr target=(src1+imm)&~1 (bit0 cleared). b* target=pc+imm.
//    All sums wrap modulo 2^XLEN. jal/jalr are always taken.
//  - mispredict = act & ((taken!=ex_pred_taken) | (taken & target!=ex_pred_target)).
//    redirect_pc = pc+4 when not taken.
//  - BTB entry: {valid, tag=pc[XLEN-1:IDX+2], target, cnt[1:0], uncond}. index=pc[IDX+1:2].
//  - Lookup: hit = valid & tag match. pred_taken = hit & (uncond | cnt[1]).
//    pred_target = entry.target. When there is no hit, pred_target=0.
//  - Train (posedge, when act):
//    - hit and taken: cnt=sat_inc, target=resolved target, uncond=jal|jalr.
//    - hit and not taken: cnt=sat_dec. The target is kept.
//    - miss and taken: allocate and overwrite the index. Set cnt=2'b10; uncond per type.
//    - miss and not taken: no allocation.
//  - Lookup and train on the same index in the same cycle: the lookup returns the
//    pre-update contents. The update is visible the next cycle.
//  - Counters: br_count += act. mis_count += mispredict. Both hold at all-ones
//    (saturate, no wrap).
//  - Reset (sync): all valid=0. cnt=2'b01 (weakly not-taken). br_count=mis_count=0.
//    pred_taken=0, pred_target=0.
//  - rst asserted together with act: reset wins. No train, no count.
//  - Resolution outputs stay combinational during rst.
// TESTING
//  1 rst 1 cycle; lookup any pc -> pred_taken=0, pred_target=0, br/mis counts 0.
//  2 beq pc=0x100 imm=0x40 src1=src2=5, ex_pred_taken=0 -> taken=1, target=0x140,
//    mispredict=1. Next cycle lookup 0x100 -> pred_taken=1, pred_target=0x140.
//  3 bltu src1=1 src2=0xFFFFFFFF -> taken. blt same operands -> not taken, redirect_pc=pc+4.
//  4 jalr src1=0x2001 imm=0x4 -> target=0x2004, taken=1. Then 3x not-taken on trained
//    beq 0x100 -> cnt 11->10->01, pred_taken=0 after the 2nd update.
//  5 Alias: pc 0x100 and 0x100+4*ENTRIES both taken -> 2nd overwrites. Lookup 0x100
//    misses. Same-cycle lookup/update -> old data returned.
//  6 ex_flush=1 or jump_type=8'h03 -> no train, counts unchanged, mispredict=0. Preload
//    mis_count near all-ones -> saturates.

Source files
------------

// File: rtl/bru_bpred.sv
`default_nettype none
// ============================================================================
// bru_bpred : branch resolution unit with direct-mapped BTB, 2-bit direction
//             predictor and saturating branch/mispredict counters
// Revision  : 1.0
// ============================================================================
module bru_bpred #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pred_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic             ex_flush,
  input  logic [7:0]       jump_type,
  input  logic [XLEN-1:0]  src1,
  input  logic [XLEN-1:0]  src2,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             taken,
  output logic [XLEN-1:0]  target,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mis_count
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  localparam logic [7:0] C_JAL  = 8'h01;
  localparam logic [7:0] C_JALR = 8'h02;
  localparam logic [7:0] C_BEQ  = 8'h04;
  localparam logic [7:0] C_BNE  = 8'h08;
  localparam logic [7:0] C_BLT  = 8'h10;
  localparam logic [7:0] C_BGE  = 8'h20;
  localparam logic [7:0] C_BLTU = 8'h40;
  localparam logic [7:0] C_BGEU = 8'h80;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0]  tgt_q   [ENTRIES];
  logic [1:0]       cnt_q   [ENTRIES];
  logic             unc_q   [ENTRIES];

  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] mis_count_q, mis_count_d;

  // ---------------------------------------------------------------- lookup
  logic [IDX-1:0] w_l_idx;
  logic           w_l_hit;
  logic           w_unused;

  assign w_l_idx     = pred_pc[IDX+1:2];
  assign w_l_hit     = valid_q[w_l_idx] && (tag_q[w_l_idx] == pred_pc[XLEN-1:IDX+2]);
  assign pred_taken  = w_l_hit && (unc_q[w_l_idx] || cnt_q[w_l_idx][1]);
  assign pred_target = w_l_hit ? tgt_q[w_l_idx] : '0;
  assign w_unused    = ^pred_pc[1:0];

  // ------------------------------------------------------------ resolution
  logic            w_onehot;
  logic            w_act;
  logic            w_cond;
  logic [XLEN-1:0] w_pc_imm;
  logic [XLEN-1:0] w_rs_imm;
  logic [XLEN-1:0] w_pc_4;

  assign w_onehot = (jump_type != 8'h00) && ((jump_type & (jump_type - 8'd1)) == 8'h00);
  assign w_act    = ex_valid && !ex_flush && w_onehot;
  assign w_pc_imm = pc + imm;
  assign w_rs_imm = src1 + imm;
  assign w_pc_4   = pc + XLEN'(4);

  always_comb begin
    w_cond = 1'b0;
    case (jump_type)
      C_JAL, C_JALR: w_cond = 1'b1;
      C_BEQ:         w_cond = (src1 == src2);
      C_BNE:         w_cond = (src1 != src2);
      C_BLT:         w_cond = ($signed(src1) <  $signed(src2));
      C_BGE:         w_cond = ($signed(src1) >= $signed(src2));
      C_BLTU:        w_cond = (src1 <  src2);
      C_BGEU:        w_cond = (src1 >= src2);
      default:       w_cond = 1'b0;
    endcase
  end

  assign taken       = w_act && w_cond;
  assign target      = (jump_type == C_JALR) ? {w_rs_imm[XLEN-1:1], 1'b0} : w_pc_imm;
  assign mispredict  = w_act && ((taken != ex_pred_taken) ||
                                 (taken && (target != ex_pred_target)));
  assign redirect_pc = taken ? target : w_pc_4;

  // ---------------------------------------------------------------- train
  logic [IDX-1:0]   w_e_idx;
  logic [TAG_W-1:0] w_e_tag;
  logic             w_e_hit;
  logic             wr_en_d;
  logic [1:0]       cnt_d;
  logic [XLEN-1:0]  tgt_d;
  logic             unc_d;

  assign w_e_idx = pc[IDX+1:2];
  assign w_e_tag = pc[XLEN-1:IDX+2];
  assign w_e_hit = valid_q[w_e_idx] && (tag_q[w_e_idx] == w_e_tag);

  always_comb begin
    wr_en_d = 1'b0;
    cnt_d   = cnt_q[w_e_idx];
    tgt_d   = tgt_q[w_e_idx];
    unc_d   = unc_q[w_e_idx];
    if (w_act) begin
      if (w_e_hit) begin
        wr_en_d = 1'b1;
        if (taken) begin
          cnt_d = (cnt_q[w_e_idx] == 2'b11) ? 2'b11 : cnt_q[w_e_idx] + 2'd1;
          tgt_d = target;
          unc_d = jump_type[0] | jump_type[1];
        end else begin
          cnt_d = (cnt_q[w_e_idx] == 2'b00) ? 2'b00 : cnt_q[w_e_idx] - 2'd1;
        end
      end else if (taken) begin
        // Not-taken misses never allocate, so cold branches stay out of the table.
        wr_en_d = 1'b1;
        cnt_d   = 2'b10;
        tgt_d   = target;
        unc_d   = jump_type[0] | jump_type[1];
      end
    end
  end

  assign br_count_d  = (w_act && (br_count_q != '1)) ? br_count_q + CNT_W'(1) : br_count_q;
  assign mis_count_d = (mispredict && (mis_count_q != '1)) ? mis_count_q + CNT_W'(1)
                                                           : mis_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= 2'b01;
        unc_q[i]   <= 1'b0;
      end
      br_count_q  <= '0;
      mis_count_q <= '0;
    end else begin
      if (wr_en_d) begin
        valid_q[w_e_idx] <= 1'b1;
        tag_q[w_e_idx]   <= w_e_tag;
        tgt_q[w_e_idx]   <= tgt_d;
        cnt_q[w_e_idx]   <= cnt_d;
        unc_q[w_e_idx]   <= unc_d;
      end
      br_count_q  <= br_count_d;
      mis_count_q <= mis_count_d;
    end
  end

  assign br_count  = br_count_q;
  assign mis_count = mis_count_q;

endmodule
`default_nettype wire

// File: tb/tb_bru_bpred.sv
`default_nettype none
// tb_bru_bpred : scoreboard bench; a behavioural BTB/predictor model produces expected
// responses per cycle, a negedge monitor pops and compares them.
module tb_bru_bpred;
  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int IDX     = 4;
  localparam int CNT_W   = 5;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [XLEN-1:0]  pred_pc = '0;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             ex_valid = 1'b0;
  logic             ex_flush = 1'b0;
  logic [7:0]       jump_type = 8'h00;
  logic [XLEN-1:0]  src1 = '0, src2 = '0, pc = '0, imm = '0;
  logic             ex_pred_taken = 1'b0;
  logic [XLEN-1:0]  ex_pred_target = '0;
  logic             taken;
  logic [XLEN-1:0]  target;
  logic             mispredict;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] br_count, mis_count;

  bru_bpred #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .ex_valid(ex_valid), .ex_flush(ex_flush),
    .jump_type(jump_type), .src1(src1), .src2(src2), .pc(pc), .imm(imm),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .taken(taken), .target(target), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .br_count(br_count), .mis_count(mis_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pt;
    logic [31:0] ptg;
    logic        tk;
    logic [31:0] tg;
    logic        mp;
    logic [31:0] rp;
    int          bc;
    int          mc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_mis = 0;

  // Reference model: each slot remembers the full pc that owns it.
  bit          m_valid [ENTRIES];
  logic [31:0] m_owner [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_cnt   [ENTRIES];
  bit          m_unc   [ENTRIES];
  int          m_br, m_mis;

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_cnt[i] = 1; m_unc[i] = 0; m_tgt[i] = 0; m_owner[i] = 0;
    end
    m_br = 0; m_mis = 0;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int i = int'((a >> 2) % ENTRIES);
    return m_valid[i] && ((m_owner[i] >> (IDX + 2)) == (a >> (IDX + 2)));
  endfunction

  function automatic void model_lookup(input logic [31:0] a, output logic pt, output logic [31:0] ptg);
    int i = int'((a >> 2) % ENTRIES);
    bit h = model_hit(a);
    pt  = h && (m_unc[i] || m_cnt[i] >= 2);
    ptg = h ? m_tgt[i] : 32'h0;
  endfunction

  function automatic void model_step();
    exp_t e;
    bit act, cond;
    int i;
    act = ex_valid && !ex_flush && ($countones(jump_type) == 1);
    case (jump_type)
      8'h01, 8'h02: cond = 1;
      8'h04: cond = (src1 == src2);
      8'h08: cond = (src1 != src2);
      8'h10: cond = ($signed(src1) < $signed(src2));
      8'h20: cond = ($signed(src1) >= $signed(src2));
      8'h40: cond = (src1 < src2);
      8'h80: cond = (src1 >= src2);
      default: cond = 0;
    endcase
    model_lookup(pred_pc, e.pt, e.ptg);
    e.tk = act && cond;
    e.tg = (jump_type == 8'h02) ? ((src1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    e.mp = act && ((e.tk != ex_pred_taken) || (e.tk && e.tg != ex_pred_target));
    e.rp = e.tk ? e.tg : pc + 32'd4;
    e.bc = m_br;
    e.mc = m_mis;
    q.push_back(e);
    if (rst) begin
      model_reset();
    end else if (act) begin
      i = int'((pc >> 2) % ENTRIES);
      if (model_hit(pc)) begin
        if (e.tk) begin
          m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
          m_tgt[i] = e.tg;
          m_unc[i] = (jump_type == 8'h01) || (jump_type == 8'h02);
        end else begin
          m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
        end
      end else if (e.tk) begin
        m_valid[i] = 1; m_owner[i] = pc; m_tgt[i] = e.tg; m_cnt[i] = 2;
        m_unc[i] = (jump_type == 8'h01) || (jump_type == 8'h02);
      end
      m_br = (m_br == CMAX) ? CMAX : m_br + 1;
      if (e.mp) m_mis = (m_mis == CMAX) ? CMAX : m_mis + 1;
    end
  endfunction

  task automatic drv(input bit r, input bit v, input bit f, input logic [7:0] j,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                     input logic [31:0] im, input bit ept, input logic [31:0] eptg,
                     input logic [31:0] lpc);
    @(posedge clk);
    #1;
    rst = r; ex_valid = v; ex_flush = f; jump_type = j; src1 = a; src2 = b;
    pc = p; imm = im; ex_pred_taken = ept; ex_pred_target = eptg; pred_pc = lpc;
    model_step();
  endtask

  task automatic idle(input logic [31:0] lpc);
    drv(0, 0, 0, 8'h00, 0, 0, 32'h0, 0, 0, 0, lpc);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s vec=%0d got=%h expected=%h t=%0t", nm, n_vec, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      chk("pred_taken",  32'(pred_taken),  32'(e.pt));
      chk("pred_target", pred_target,      e.ptg);
      chk("taken",       32'(taken),       32'(e.tk));
      chk("target",      target,           e.tg);
      chk("mispredict",  32'(mispredict),  32'(e.mp));
      chk("redirect_pc", redirect_pc,      e.rp);
      chk("br_count",    32'(br_count),    32'(e.bc));
      chk("mis_count",   32'(mis_count),   32'(e.mc));
    end
  end

  function automatic logic [31:0] rnd_pc();
    return 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'(64 * $urandom_range(0, 2));
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 3));
      1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
      2: return 32'h8000_0000 + 32'($urandom_range(0, 1));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic        ept;
    logic [31:0] eptg, p;
    logic [7:0]  j;
    int          r;
    model_reset();
    // power-up reset is taken on the first edge; checking starts after it
    idle(32'h100);
    idle(32'h500);
    // beq taken on a cold entry
    drv(0, 1, 0, 8'h04, 5, 5, 32'h100, 32'h40, 0, 0, 32'h100);
    idle(32'h100);
    // unsigned vs signed compares on the same operands
    drv(0, 1, 0, 8'h40, 1, 32'hFFFF_FFFF, 32'h180, 32'h10, 0, 0, 32'h180);
    drv(0, 1, 0, 8'h10, 1, 32'hFFFF_FFFF, 32'h184, 32'h10, 0, 0, 32'h184);
    // jalr clears bit 0
    drv(0, 1, 0, 8'h02, 32'h2001, 2, 32'h1C0, 32'h4, 0, 0, 32'h1C0);
    idle(32'h1C0);
    // saturate beq 0x100 then walk it down
    drv(0, 1, 0, 8'h04, 7, 7, 32'h100, 32'h40, 1, 32'h140, 32'h100);
    for (int k = 0; k < 3; k++) drv(0, 1, 0, 8'h04, 1, 2, 32'h100, 32'h40, 1, 32'h140, 32'h100);
    idle(32'h100);
    // alias on same index overwrites, then same-cycle lookup returns old data
    drv(0, 1, 0, 8'h04, 3, 3, 32'h100, 32'h40, 0, 0, 32'h100);
    drv(0, 1, 0, 8'h04, 3, 3, 32'h140, 32'h20, 0, 0, 32'h100);
    idle(32'h100);
    idle(32'h140);
    drv(0, 1, 0, 8'h01, 0, 0, 32'h208, 32'h80, 0, 0, 32'h208);
    idle(32'h208);
    // flush and multi-hot do nothing
    drv(0, 1, 1, 8'h04, 3, 3, 32'h24C, 32'h8, 0, 0, 32'h24C);
    drv(0, 1, 0, 8'h03, 3, 3, 32'h250, 32'h8, 0, 0, 32'h250);
    idle(32'h24C);
    idle(32'h250);
    // reset coincident with an active branch
    drv(1, 1, 0, 8'h04, 3, 3, 32'h260, 32'h8, 0, 0, 32'h208);
    idle(32'h208);
    idle(32'h260);
    // drive counters into saturation
    for (int k = 0; k < 40; k++) drv(0, 1, 0, 8'h01, 0, 0, 32'h300, 32'h10, 0, 0, 32'h300);
    idle(32'h300);
    drv(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 32'h300);
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      p = rnd_pc();
      r = $urandom_range(0, 11);
      if (r < 8)       j = 8'(1 << r);
      else if (r == 8) j = 8'h00;
      else if (r == 9) j = 8'h03;
      else             j = 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 9) < 7) model_lookup(p, ept, eptg);
      else begin ept = 1'($urandom); eptg = rnd_pc(); end
      drv(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 9) == 0), j, rnd_op(), rnd_op(), p,
          32'($urandom_range(0, 255) * 4) - 32'd512, ept, eptg, rnd_pc());
      if (n == 300) begin
        drv(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, rnd_pc());
      end
    end
    idle(32'h100);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_mis++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
`default_nettype wire
